// File: rtl/pwm_duty_ramp_if.sv
// Target-duty handshake bundle for pwm_duty_ramp.
// The producer (master) offers a target duty plus its step interval;
// the ramp (slave) answers with tgt_ready.
interface pwm_duty_ramp_if #(
   parameter int DUTY_W = 3,
   parameter int DIV_W  = 8
);
   logic              tgt_valid;
   logic [DUTY_W-1:0] tgt_duty;
   logic [DIV_W-1:0]  step_div;
   logic              tgt_ready;

   modport master (
      output tgt_valid,
      output tgt_duty,
      output step_div,
      input  tgt_ready
   );

   modport slave (
      input  tgt_valid,
      input  tgt_duty,
      input  step_div,
      output tgt_ready
   );
endinterface

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slew-limited duty source feeding the PWM stage.
// Walks o_duty one LSB at a time toward an accepted target, stepping only
// on PWM period boundaries (i_pwm_wrap), once every `div` wraps.
//
// Optional feature macro: PWM_DUTY_RAMP_RETARGET_EN
//   defined   -> a new target may be accepted while a ramp is running
//   undefined -> targets are only accepted while idle
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | duty parked (at target or forced off), ready for a target
// S_UP   | duty below target, incrementing on step boundaries
// S_DOWN | duty above target, decrementing on step boundaries
module pwm_duty_ramp #(
   parameter int DUTY_W = 3,
   parameter int DIV_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_enable,
   input  logic              i_pwm_wrap,
   pwm_duty_ramp_if.slave    tgt_if,
   output logic [DUTY_W-1:0] o_duty,
   output logic              o_busy,
   output logic              o_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_armed;
   logic [DUTY_W-1:0] r_duty;
   logic [DUTY_W-1:0] r_tgt;
   logic [DIV_W-1:0]  r_div;
   logic [DIV_W-1:0]  r_div_cnt;
   logic              r_done;

   state_t            w_state_nxt;
   logic [DUTY_W-1:0] w_duty_nxt;
   logic [DUTY_W-1:0] w_tgt_nxt;
   logic [DIV_W-1:0]  w_div_nxt;
   logic [DIV_W-1:0]  w_div_cnt_nxt;
   logic              w_done_nxt;
   logic              w_tgt_ready;
   logic              w_accept;
   logic [DIV_W-1:0]  w_div_in;
   logic [DIV_W-1:0]  w_div_m1;
   logic              w_step_due;

   // Handshake: ready only once armed after reset and while enabled
   always_comb begin
`ifdef PWM_DUTY_RAMP_RETARGET_EN
      w_tgt_ready = r_armed & i_enable;
`else
      w_tgt_ready = r_armed & i_enable & (r_state == S_IDLE);
`endif
      w_accept = tgt_if.tgt_valid & w_tgt_ready;
      // A zero interval would never terminate the divider; treat it as 1
      w_div_in = (tgt_if.step_div == '0) ? DIV_W'(1) : tgt_if.step_div;
      w_div_m1 = r_div - DIV_W'(1);
   end

   // Next-state: disable override, then the step, then any acceptance
   always_comb begin
      w_state_nxt   = r_state;
      w_duty_nxt    = r_duty;
      w_tgt_nxt     = r_tgt;
      w_div_nxt     = r_div;
      w_div_cnt_nxt = r_div_cnt;
      w_done_nxt    = 1'b0;
      w_step_due    = 1'b0;

      if (!i_enable) begin
         w_state_nxt   = S_IDLE;
         w_duty_nxt    = '0;
         w_div_cnt_nxt = '0;
      end else begin
         if ((r_state != S_IDLE) && i_pwm_wrap) begin
            if (r_div_cnt == w_div_m1) begin
               w_step_due    = 1'b1;
               w_div_cnt_nxt = '0;
            end else begin
               w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
            end
         end

         // Compare against the target before moving so duty can never
         // overshoot or wrap, whatever the direction register says.
         if (w_step_due) begin
            if ((r_state == S_UP) && (r_duty < r_tgt)) begin
               w_duty_nxt = r_duty + DUTY_W'(1);
            end else if ((r_state == S_DOWN) && (r_duty > r_tgt)) begin
               w_duty_nxt = r_duty - DUTY_W'(1);
            end
            if (w_duty_nxt == r_tgt) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end

         // Acceptance sees the already-stepped duty, so a step and a
         // retarget in the same cycle pick direction from the new value.
         if (w_accept) begin
            w_tgt_nxt     = tgt_if.tgt_duty;
            w_div_nxt     = w_div_in;
            w_div_cnt_nxt = '0;
            if (tgt_if.tgt_duty > w_duty_nxt) begin
               w_state_nxt = S_UP;
               w_done_nxt  = 1'b0;
            end else if (tgt_if.tgt_duty < w_duty_nxt) begin
               w_state_nxt = S_DOWN;
               w_done_nxt  = 1'b0;
            end else begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
      end
   end

   // State, datapath and done-pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_duty    <= '0;
         r_tgt     <= '0;
         r_div     <= DIV_W'(1);
         r_div_cnt <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_duty    <= w_duty_nxt;
         r_tgt     <= w_tgt_nxt;
         r_div     <= w_div_nxt;
         r_div_cnt <= w_div_cnt_nxt;
         r_done    <= w_done_nxt;
      end
   end

   // Arm one clock after reset release so ready is low in the first cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed <= 1'b0;
      end else begin
         r_armed <= 1'b1;
      end
   end

   assign tgt_if.tgt_ready = w_tgt_ready;
   assign o_duty           = r_duty;
   assign o_busy           = (r_state != S_IDLE);
   assign o_done           = r_done;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: a table of ramp transactions plus
// hand-written sequences for disable, mid-ramp reset and retargeting.
module tb_pwm_duty_ramp;
   localparam int DUTY_W = 3;
   localparam int DIV_W  = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic              pwm_wrap;
   logic [DUTY_W-1:0] duty;
   logic              busy;
   logic              done;

   pwm_duty_ramp_if #(.DUTY_W(DUTY_W), .DIV_W(DIV_W)) tgt_if();

   pwm_duty_ramp #(.DUTY_W(DUTY_W), .DIV_W(DIV_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_enable   (enable),
      .i_pwm_wrap (pwm_wrap),
      .tgt_if     (tgt_if.slave),
      .o_duty     (duty),
      .o_busy     (busy),
      .o_done     (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int done_duty = -1;

   always @(negedge clk) begin
      if (done) begin
         done_cnt  = done_cnt + 1;
         done_duty = int'(duty);
      end
   end

   typedef struct {
      int tgt;
      int div;
      int exp_wraps;
      int exp_final;
      bit exp_busy;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp = n_cmp + 1;
      if (act != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wrap_pulse;
      pwm_wrap = 1'b1;
      tick();
      pwm_wrap = 1'b0;
      repeat (7) tick();
   endtask

   task automatic accept(input int t, input int d);
      bit got;
      got = 1'b0;
      tgt_if.tgt_valid = 1'b1;
      tgt_if.tgt_duty  = t[DUTY_W-1:0];
      tgt_if.step_div  = d[DIV_W-1:0];
      for (int i = 0; i < 50 && !got; i++) begin
         if (tgt_if.tgt_ready) got = 1'b1;
         tick();
      end
      tgt_if.tgt_valid = 1'b0;
      chk("accept_ready", int'(got), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cur;
      int dc0;
      int wraps;
      int divv;
      int steps;
      int dd;
      int expd;
      bit got;

      vecs[0] = '{tgt: 5, div: 2, exp_wraps: 10, exp_final: 5, exp_busy: 1'b1};
      vecs[1] = '{tgt: 1, div: 0, exp_wraps: 4,  exp_final: 1, exp_busy: 1'b1};
      vecs[2] = '{tgt: 7, div: 1, exp_wraps: 6,  exp_final: 7, exp_busy: 1'b1};
      vecs[3] = '{tgt: 7, div: 3, exp_wraps: 0,  exp_final: 7, exp_busy: 1'b0};
      vecs[4] = '{tgt: 0, div: 1, exp_wraps: 7,  exp_final: 0, exp_busy: 1'b1};
      vecs[5] = '{tgt: 0, div: 5, exp_wraps: 0,  exp_final: 0, exp_busy: 1'b0};
      vecs[6] = '{tgt: 2, div: 3, exp_wraps: 6,  exp_final: 2, exp_busy: 1'b1};

      rst_n            = 1'b0;
      enable           = 1'b1;
      pwm_wrap         = 1'b0;
      tgt_if.tgt_valid = 1'b0;
      tgt_if.tgt_duty  = '0;
      tgt_if.step_div  = '0;

      repeat (3) tick();
      chk("rst_duty",  int'(duty), 0);
      chk("rst_busy",  int'(busy), 0);
      chk("rst_done",  int'(done), 0);
      chk("rst_ready", int'(tgt_if.tgt_ready), 0);
      #3 rst_n = 1'b1;
      #1 chk("rel_ready_first", int'(tgt_if.tgt_ready), 0);
      tick();
      chk("rel_ready_armed", int'(tgt_if.tgt_ready), 1);

      // Table of ramp transactions, each starting from the previous final duty
      cur = 0;
      for (int i = 0; i < 7; i++) begin
         dc0   = done_cnt;
         divv  = (vecs[i].div == 0) ? 1 : vecs[i].div;
         steps = (vecs[i].tgt > cur) ? vecs[i].tgt - cur : cur - vecs[i].tgt;
         accept(vecs[i].tgt, vecs[i].div);
         chk("vec_busy_after_accept", int'(busy), int'(vecs[i].exp_busy));
         wraps = 0;
         while (busy && wraps < vecs[i].exp_wraps + 5) begin
            wrap_pulse();
            wraps = wraps + 1;
            dd = wraps / divv;
            if (dd > steps) dd = steps;
            expd = (vecs[i].tgt > cur) ? cur + dd : cur - dd;
            chk("vec_duty_mid", int'(duty), expd);
         end
         repeat (2) tick();
         chk("vec_wraps",     wraps, vecs[i].exp_wraps);
         chk("vec_final",     int'(duty), vecs[i].exp_final);
         chk("vec_done_cnt",  done_cnt - dc0, 1);
         chk("vec_done_duty", done_duty, vecs[i].exp_final);
         chk("vec_busy_end",  int'(busy), 0);
         cur = vecs[i].exp_final;
      end

      // Disable mid-ramp: forced off next edge, no done, ready held low
      dc0 = done_cnt;
      accept(6, 1);
      wrap_pulse();
      chk("dis_duty_before", int'(duty), 3);
      enable = 1'b0;
      tick();
      chk("dis_duty",  int'(duty), 0);
      chk("dis_busy",  int'(busy), 0);
      chk("dis_ready", int'(tgt_if.tgt_ready), 0);
      wrap_pulse();
      chk("dis_duty_hold",  int'(duty), 0);
      chk("dis_ready_hold", int'(tgt_if.tgt_ready), 0);
      enable = 1'b1;
      #1 chk("reen_ready", int'(tgt_if.tgt_ready), 1);
      chk("dis_no_done", done_cnt - dc0, 0);

      // Asynchronous reset between edges in the middle of a ramp
      dc0 = done_cnt;
      accept(6, 1);
      wrap_pulse();
      wrap_pulse();
      chk("rstmid_duty_before", int'(duty), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_duty",  int'(duty), 0);
      chk("rstmid_busy",  int'(busy), 0);
      chk("rstmid_ready", int'(tgt_if.tgt_ready), 0);
      tick();
      #3 rst_n = 1'b1;
      #1 chk("rstmid_ready_first", int'(tgt_if.tgt_ready), 0);
      tick();
      chk("rstmid_ready_armed", int'(tgt_if.tgt_ready), 1);
      chk("rstmid_no_done", done_cnt - dc0, 0);

      // New target offered partway through a ramp 0 -> 7
      dc0 = done_cnt;
      accept(7, 1);
      repeat (4) wrap_pulse();
      chk("rt_duty_at_offer", int'(duty), 4);
      tgt_if.tgt_valid = 1'b1;
      tgt_if.tgt_duty  = 3'd2;
      tgt_if.step_div  = 8'd1;
`ifdef PWM_DUTY_RAMP_RETARGET_EN
      chk("rt_ready_busy", int'(tgt_if.tgt_ready), 1);
      tick();
      tgt_if.tgt_valid = 1'b0;
      chk("rt_busy_down", int'(busy), 1);
      wrap_pulse();
      chk("rt_duty_3", int'(duty), 3);
      wrap_pulse();
      chk("rt_duty_2", int'(duty), 2);
      chk("rt_busy_end", int'(busy), 0);
      repeat (2) tick();
      chk("rt_done_cnt", done_cnt - dc0, 1);
`else
      chk("rt_ready_busy", int'(tgt_if.tgt_ready), 0);
      got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
         if (tgt_if.tgt_ready) begin
            got = 1'b1;
            chk("rt_duty_at_accept", int'(duty), 7);
            tick();
         end else begin
            pwm_wrap = (c % 8 == 0);
            tick();
            pwm_wrap = 1'b0;
         end
      end
      tgt_if.tgt_valid = 1'b0;
      chk("rt_accept_late", int'(got), 1);
      chk("rt_busy_down", int'(busy), 1);
      repeat (5) wrap_pulse();
      chk("rt_duty_2", int'(duty), 2);
      chk("rt_busy_end", int'(busy), 0);
      repeat (2) tick();
      chk("rt_done_cnt", done_cnt - dc0, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
